regbank_sp_gen: RTL and testbench

Parametrised register bank that succeeds the fixed 17-entry bank. It provides a hard-wired zero register, NUM_REGS-1 general registers and a dedicated stack-pointer (SP) register at index NUM_REGS. Two read ports and one write port are supported, with optional same-cycle write bypass. SP increment/decrement has configurable step and bounds, plus sticky overflow/underflow flags. It sits between the instruction register decoder and the datapath ALU/memory stage.

---
 rtl/regbank_sp_gen.sv | 146 ++++++++++++++
 tb/tb_regbank_sp_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/regbank_sp_gen.sv
// Register bank with hard-wired r0, NUM_REGS-1 general registers and a bounded
// stack pointer at index NUM_REGS; two combinational read ports, one write port.
module regbank_sp_gen #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned SP_RESET = 900,
  parameter int unsigned SP_STEP  = 4,
  parameter int unsigned SP_MIN   = 0,
  parameter int unsigned SP_MAX   = 4092,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [ADDR_W-1:0] rd2,
  input  logic              re1,
  input  logic              re2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  input  logic [ADDR_W-1:0] wr,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        incdec,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_ovf,
  output logic              sp_unf,
  input  logic              flag_clr
);

  localparam int unsigned NUM_ADDR = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] view [0:NUM_ADDR-1];

  logic              wr_valid;
  logic              sp_wr;
  logic              hit1;
  logic              hit2;
  logic [DATA_W:0]   sp_inc_ext;
  logic              inc_refuse;
  logic              dec_refuse;
  logic [DATA_W-1:0] sp_next;
  logic              ovf_set;
  logic              unf_set;

  // Flat read view: r0 and addresses above SP read as zero.
  for (genvar g = 0; g < NUM_ADDR; g++) begin : g_view
    if (g == 0) begin : g_zero
      assign view[g] = {DATA_W{1'b0}};
    end else if (g < NUM_REGS) begin : g_gpr
      assign view[g] = regs[g];
    end else if (g == NUM_REGS) begin : g_sp
      assign view[g] = sp;
    end else begin : g_oob
      assign view[g] = {DATA_W{1'b0}};
    end
  end

  assign wr_valid = we && (wr != {ADDR_W{1'b0}}) && (wr <= SP_IDX);
  assign sp_wr    = we && (wr == SP_IDX);
  assign hit1     = (BYPASS != 0) && wr_valid && (wr == rd1);
  assign hit2     = (BYPASS != 0) && wr_valid && (wr == rd2);

  // Read ports: gated to zero when disabled, forward write data on an address match.
  always_comb begin
    data_out1 = {DATA_W{1'b0}};
    data_out2 = {DATA_W{1'b0}};
    if (re1) begin
      data_out1 = hit1 ? data_in : view[rd1];
    end else begin
      data_out1 = {DATA_W{1'b0}};
    end
    if (re2) begin
      data_out2 = hit2 ? data_in : view[rd2];
    end else begin
      data_out2 = {DATA_W{1'b0}};
    end
  end

  // Bound checks are done one bit wider so SP near the top of the range cannot wrap.
  assign sp_inc_ext = {1'b0, sp} + (DATA_W+1)'(SP_STEP);
  assign inc_refuse = sp_inc_ext > (DATA_W+1)'(SP_MAX);
  assign dec_refuse = {1'b0, sp} < ((DATA_W+1)'(SP_MIN) + (DATA_W+1)'(SP_STEP));

  // Next SP value: direct write beats inc/dec; refused ops hold SP and raise a flag.
  always_comb begin
    sp_next = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (sp_wr) begin
      sp_next = data_in;
    end else begin
      case (incdec)
        2'b01: begin
          if (inc_refuse) begin
            ovf_set = 1'b1;
          end else begin
            sp_next = sp_inc_ext[DATA_W-1:0];
          end
        end
        2'b10: begin
          if (dec_refuse) begin
            unf_set = 1'b1;
          end else begin
            sp_next = sp - DATA_W'(SP_STEP);
          end
        end
        default: sp_next = sp;
      endcase
    end
  end

  // General-register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (we && (wr == ADDR_W'(i))) begin
          regs[i] <= data_in;
        end
      end
    end
  end

  // SP and sticky flags; a new refusal wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp     <= DATA_W'(SP_RESET);
      sp_ovf <= 1'b0;
      sp_unf <= 1'b0;
    end else begin
      sp     <= sp_next;
      sp_ovf <= ovf_set | (sp_ovf & ~flag_clr);
      sp_unf <= unf_set | (sp_unf & ~flag_clr);
    end
  end

  assign sp_out = sp;

endmodule

// File: tb/tb_regbank_sp_gen.sv
// Directed bench for regbank_sp_gen at default parameters.
module tb_regbank_sp_gen;

  logic        clk;
  logic        rst;
  logic [4:0]  rd1, rd2, wr;
  logic        re1, re2, we, flag_clr;
  logic [31:0] data_out1, data_out2, data_in, sp_out;
  logic [1:0]  incdec;
  logic        sp_ovf, sp_unf;
  int          checks;
  int          errors;

  regbank_sp_gen dut (
    .clk(clk), .rst(rst), .rd1(rd1), .rd2(rd2), .re1(re1), .re2(re2),
    .data_out1(data_out1), .data_out2(data_out2), .wr(wr), .we(we),
    .data_in(data_in), .incdec(incdec), .sp_out(sp_out), .sp_ovf(sp_ovf),
    .sp_unf(sp_unf), .flag_clr(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; wr = 5'd0; data_in = 32'd0; incdec = 2'b00;
    flag_clr = 1'b0; re1 = 1'b0; re2 = 1'b0; rd1 = 5'd0; rd2 = 5'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (sp_out !== 32'd900) begin errors++; $display("FAIL reset_sp: got %0d expected 900", sp_out); end
    checks++; if (sp_ovf !== 1'b0 || sp_unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", sp_ovf, sp_unf); end
    re1 = 1'b1; rd1 = 5'd16; #1;
    checks++; if (data_out1 !== 32'd900) begin errors++; $display("FAIL reset_read_sp: got %0d expected 900", data_out1); end
    rd1 = 5'd5; #1;
    checks++; if (data_out1 !== 32'd0) begin errors++; $display("FAIL reset_read_r5: got %0h expected 0", data_out1); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we = 1'b1; wr = 5'd3; data_in = 32'hDEADBEEF; re1 = 1'b1; rd1 = 5'd3; #1;
    checks++; if (data_out1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_r3: got %0h expected deadbeef", data_out1); end
    @(negedge clk);
    we = 1'b0; data_in = 32'h0; #1;
    checks++; if (data_out1 !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_r3: got %0h expected deadbeef", data_out1); end
    we = 1'b1; wr = 5'd0; data_in = 32'h1234; rd1 = 5'd0; #1;
    checks++; if (data_out1 !== 32'd0) begin errors++; $display("FAIL r0_bypass: got %0h expected 0", data_out1); end
    @(negedge clk);
    we = 1'b0; #1;
    checks++; if (data_out1 !== 32'd0) begin errors++; $display("FAIL r0_write: got %0h expected 0", data_out1); end
    re2 = 1'b0; rd2 = 5'd3; #1;
    checks++; if (data_out2 !== 32'd0) begin errors++; $display("FAIL re2_off: got %0h expected 0", data_out2); end
    re2 = 1'b1; #1;
    checks++; if (data_out2 !== 32'hDEADBEEF) begin errors++; $display("FAIL re2_r3: got %0h expected deadbeef", data_out2); end
    we = 1'b1; wr = 5'd20; data_in = 32'h55; rd2 = 5'd20; #1;
    checks++; if (data_out2 !== 32'd0) begin errors++; $display("FAIL oob_bypass: got %0h expected 0", data_out2); end
    @(negedge clk);
    we = 1'b0; #1;
    checks++; if (data_out2 !== 32'd0 || sp_out !== 32'd900) begin errors++; $display("FAIL oob_write: got rd=%0h sp=%0d expected 0 900", data_out2, sp_out); end
  endtask

  task automatic test_sp_ops();
    logic [31:0] exp_sp;
    exp_sp = 32'd900;
    @(negedge clk);
    incdec = 2'b01; rd1 = 5'd16;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_sp = exp_sp + 32'd4;
      checks++; if (sp_out !== exp_sp) begin errors++; $display("FAIL sp_inc%0d: got %0d expected %0d", i, sp_out, exp_sp); end
    end
    @(negedge clk); incdec = 2'b10;
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd908) begin errors++; $display("FAIL sp_dec: got %0d expected 908", sp_out); end
    @(negedge clk); incdec = 2'b11;
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd908 || data_out1 !== 32'd908) begin errors++; $display("FAIL sp_hold11: got sp=%0d rd=%0d expected 908", sp_out, data_out1); end
    @(negedge clk); incdec = 2'b00;
  endtask

  task automatic test_bounds();
    @(negedge clk); we = 1'b1; wr = 5'd16; data_in = 32'd4088;
    @(negedge clk); we = 1'b0; incdec = 2'b01;
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd4092 || sp_ovf !== 1'b0) begin errors++; $display("FAIL inc_to_max: got sp=%0d ovf=%b expected 4092 0", sp_out, sp_ovf); end
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd4092 || sp_ovf !== 1'b1) begin errors++; $display("FAIL inc_refused: got sp=%0d ovf=%b expected 4092 1", sp_out, sp_ovf); end
    @(negedge clk); incdec = 2'b00; we = 1'b1; wr = 5'd16; data_in = 32'd4;
    @(negedge clk); we = 1'b0; incdec = 2'b10;
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd0 || sp_unf !== 1'b0 || sp_ovf !== 1'b1) begin errors++; $display("FAIL dec_to_min: got sp=%0d unf=%b ovf=%b expected 0 0 1", sp_out, sp_unf, sp_ovf); end
    @(negedge clk); incdec = 2'b00; we = 1'b1; wr = 5'd16; data_in = 32'd2;
    @(negedge clk); we = 1'b0; incdec = 2'b10;
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd2 || sp_unf !== 1'b1) begin errors++; $display("FAIL dec_refused: got sp=%0d unf=%b expected 2 1", sp_out, sp_unf); end
    @(negedge clk); incdec = 2'b00; flag_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (sp_ovf !== 1'b0 || sp_unf !== 1'b0) begin errors++; $display("FAIL flag_clr: got ovf=%b unf=%b expected 0 0", sp_ovf, sp_unf); end
    @(negedge clk); incdec = 2'b10;
    @(posedge clk); #1;
    checks++; if (sp_unf !== 1'b1 || sp_out !== 32'd2) begin errors++; $display("FAIL clr_vs_refuse: got unf=%b sp=%0d expected 1 2", sp_unf, sp_out); end
    @(negedge clk); incdec = 2'b00;
    @(posedge clk); #1;
    checks++; if (sp_unf !== 1'b0) begin errors++; $display("FAIL clr_after: got unf=%b expected 0", sp_unf); end
    @(negedge clk); flag_clr = 1'b0;
  endtask

  task automatic test_priority();
    @(negedge clk); we = 1'b1; wr = 5'd16; data_in = 32'd100; incdec = 2'b01;
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd100 || sp_ovf !== 1'b0) begin errors++; $display("FAIL wr_beats_inc: got sp=%0d ovf=%b expected 100 0", sp_out, sp_ovf); end
    @(negedge clk); wr = 5'd7; data_in = 32'd5; incdec = 2'b10;
    @(posedge clk); #1;
    checks++; if (sp_out !== 32'd96) begin errors++; $display("FAIL gpr_and_dec_sp: got %0d expected 96", sp_out); end
    @(negedge clk); we = 1'b0; incdec = 2'b00; re1 = 1'b1; rd1 = 5'd7; #1;
    checks++; if (data_out1 !== 32'd5) begin errors++; $display("FAIL gpr_and_dec_r7: got %0d expected 5", data_out1); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); we = 1'b1; wr = 5'd7; data_in = 32'd77; incdec = 2'b01; rd1 = 5'd3;
    #2 rst = 1'b1; #1;
    checks++; if (sp_out !== 32'd900 || data_out1 !== 32'd0) begin errors++; $display("FAIL async_rst: got sp=%0d r3=%0h expected 900 0", sp_out, data_out1); end
    @(negedge clk); we = 1'b0; incdec = 2'b00; rst = 1'b0; rd1 = 5'd7; #1;
    checks++; if (data_out1 !== 32'd0 || sp_out !== 32'd900) begin errors++; $display("FAIL lost_write: got r7=%0d sp=%0d expected 0 900", data_out1, sp_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_sp_ops();
    test_bounds();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
